// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and pipeline_ctrl.
// Latency: none (plain wires); controls are combinational from ctrl state and hazard inputs.
// Backpressure: memBusy_m freezes the upstream latches through the write enables carried here.
interface pipeline_ctrl_if;
  // decode / execute / memory stage hazard sources
  logic [2:0]  readReg1_d;
  logic [2:0]  readReg2_d;
  logic        useRs1_d;
  logic        useRs2_d;
  logic        memRead_e;
  logic [2:0]  writeRegSel_e;
  logic        redirect_e;
  logic        memBusy_m;
  logic        halt_m;
  // per-latch controls back to the datapath
  logic        pcWriteEn;
  logic        fdWriteEn;
  logic        deWriteEn;
  logic        emWriteEn;
  logic        mwWriteEn;
  logic        fdFlush;
  logic        deFlush;
  logic        mwFlush;
  logic        halted;
  logic [15:0] stallCount;

  modport master (
    output readReg1_d, readReg2_d, useRs1_d, useRs2_d, memRead_e,
           writeRegSel_e, redirect_e, memBusy_m, halt_m,
    input  pcWriteEn, fdWriteEn, deWriteEn, emWriteEn, mwWriteEn,
           fdFlush, deFlush, mwFlush, halted, stallCount
  );

  modport slave (
    input  readReg1_d, readReg2_d, useRs1_d, useRs2_d, memRead_e,
           writeRegSel_e, redirect_e, memBusy_m, halt_m,
    output pcWriteEn, fdWriteEn, deWriteEn, emWriteEn, mwWriteEn,
           fdFlush, deFlush, mwFlush, halted, stallCount
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory-wait freeze, redirect flushes, halt.
// Latency: controls are combinational in the same cycle; only state/pending redirect are registered.
// Backpressure: memBusy_m freezes PC..EM latches and bubbles MW until the access completes.
// Optional: define PIPE_CTRL_PERF_EN to build the saturating 16-bit stall-cycle counter.
module pipeline_ctrl (
  input  logic         clk,
  input  logic         rst,
  pipeline_ctrl_if.slave pif
);

  // one-hot so that any corrupted encoding is detectable and recovers to RUN
  typedef enum logic [3:0] {
    RUN       = 4'b0001,
    LU_BUBBLE = 4'b0010,
    MEM_WAIT  = 4'b0100,
    HALTED    = 4'b1000
  } state_t;

  state_t     state, state_nxt;
  logic       pend_redirect, pend_nxt;
  logic       load_use;
  logic [4:0] we;      // {pc, fd, de, em, mw}
  logic       fd_fl, de_fl, mw_fl, halted_o;

  assign load_use = pif.memRead_e &
                    ((pif.useRs1_d & (pif.readReg1_d == pif.writeRegSel_e)) |
                     (pif.useRs2_d & (pif.readReg2_d == pif.writeRegSel_e)));

  // state and sticky redirect registers; reset drops any pending redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      pend_redirect <= 1'b0;
    end else begin
      state         <= state_nxt;
      pend_redirect <= pend_nxt;
    end
  end

  // next state and latch controls; during reset everything writes so latches clear themselves
  always_comb begin
    we        = 5'b11111;
    fd_fl     = 1'b0;
    de_fl     = 1'b0;
    mw_fl     = 1'b0;
    halted_o  = 1'b0;
    state_nxt = state;
    pend_nxt  = pend_redirect;
    if (!rst) begin
      case (state)
        RUN, LU_BUBBLE: begin
          if (pif.halt_m) begin
            we        = 5'b00000;
            state_nxt = HALTED;
          end else if (pif.memBusy_m) begin
            we        = 5'b00001;
            mw_fl     = 1'b1;
            state_nxt = MEM_WAIT;
            pend_nxt  = pend_redirect | pif.redirect_e;
          end else if (pif.redirect_e) begin
            fd_fl     = 1'b1;
            de_fl     = 1'b1;
            state_nxt = RUN;
          end else if (load_use && (state == RUN)) begin
            // the bubble cycle itself never re-checks, so one load costs one stall
            we        = 5'b00111;
            de_fl     = 1'b1;
            state_nxt = LU_BUBBLE;
          end else begin
            state_nxt = RUN;
          end
        end
        MEM_WAIT: begin
          if (pif.memBusy_m) begin
            we       = 5'b00001;
            mw_fl    = 1'b1;
            pend_nxt = pend_redirect | pif.redirect_e;
          end else begin
            pend_nxt = 1'b0;
            if (pif.halt_m) begin
              we        = 5'b00000;
              state_nxt = HALTED;
            end else begin
              fd_fl     = pend_redirect | pif.redirect_e;
              de_fl     = pend_redirect | pif.redirect_e;
              state_nxt = RUN;
            end
          end
        end
        HALTED: begin
          we       = 5'b00000;
          halted_o = 1'b1;
        end
        default: begin
          we        = 5'b00000;
          state_nxt = RUN;
          pend_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign pif.pcWriteEn = we[4];
  assign pif.fdWriteEn = we[3];
  assign pif.deWriteEn = we[2];
  assign pif.emWriteEn = we[1];
  assign pif.mwWriteEn = we[0];
  assign pif.fdFlush   = fd_fl;
  assign pif.deFlush   = de_fl;
  assign pif.mwFlush   = mw_fl;
  assign pif.halted    = halted_o;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt;

  // count every cycle the PC is held outside of halt, sticking at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (!we[4] && (state != HALTED) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign pif.stallCount = stall_cnt;
`else
  assign pif.stallCount = 16'd0;
`endif

endmodule
